// File: rtl/mult_bist_pkg.sv
// mult_bist_pkg: shared state encoding and default widths for the mult_block BIST sequencer
package mult_bist_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, RUN, CHECK, DONE} bist_state_t;
  localparam int SIG_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/mult_bist_timer.sv
// mult_bist_timer: loadable down-counter that parks at zero and flags it
module mult_bist_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/mult_bist_ctrl.sv
// mult_bist_ctrl: BIST sequencer holding mult_block in reset, running it, and checking its signature
module mult_bist_ctrl
  import mult_bist_pkg::*;
#(
  parameter int              SIG_W        = SIG_W_DEF,
  parameter int              NUM_CYCLES   = 100,
  parameter int              RESET_CYCLES = 3,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0,
  parameter int              CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  input  logic [SIG_W-1:0] dut_signature,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig_captured,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);
  localparam int MAXC = NUM_CYCLES > RESET_CYCLES ? NUM_CYCLES : RESET_CYCLES;
  localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;
  bist_state_t      state_q, state_d;
  logic             dut_reset_q, dut_reset_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] run_q, run_d, fail_q, fail_d;
  logic             load, zero;
  logic [TW-1:0]    load_val;
  mult_bist_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    run_d   = run_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE:  state_d = (start && !abort) ? HOLD : IDLE;
      HOLD:  state_d = abort ? IDLE : (zero ? RUN : HOLD);
      RUN: begin
        state_d = abort ? IDLE : (zero ? CHECK : RUN);
        sig_d   = (!abort && zero) ? dut_signature : sig_q;
      end
      CHECK: begin
        state_d = abort ? IDLE : DONE;
        pass_d  = abort ? 1'b0 : sig_q == GOLDEN_SIG;
        run_d   = (abort || &run_q) ? run_q : run_q + CNT_W'(1);
        fail_d  = (abort || &fail_q || sig_q == GOLDEN_SIG) ? fail_q : fail_q + CNT_W'(1);
      end
      DONE:    state_d = (loop_en && !abort) ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q inside {HOLD, RUN}) pass_d = 1'b0;
    // Timer is loaded only on entry so each phase counts its full length
    load        = state_d != state_q && state_d inside {HOLD, RUN};
    load_val    = state_d == RUN ? TW'(NUM_CYCLES - 1) : TW'(RESET_CYCLES - 1);
    dut_reset_d = state_d != RUN;
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      sig_q       <= '0;
      run_q       <= '0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      dut_reset_q <= dut_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      sig_q       <= sig_d;
      run_q       <= run_d;
      fail_q      <= fail_d;
    end
  end
  assign dut_reset    = dut_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign sig_captured = sig_q;
  assign run_count    = run_q;
  assign fail_count   = fail_q;
endmodule

// File: tb/tb_mult_bist_ctrl.sv
// tb_mult_bist_ctrl: directed checks of the BIST sequencer against a counting mult_block model
module tb_mult_bist_ctrl;
  localparam logic [15:0] GOLD = 16'h3C5A;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset = 1'b1, start = 1'b0, abort = 1'b0, loop_en = 1'b0, flip = 1'b0;
  logic [15:0] mcnt, dut_signature, sig_captured;
  logic        dut_reset, busy, done, pass;
  logic [7:0]  run_count, fail_count;
  logic        reset2 = 1'b1, start2 = 1'b0, loop2 = 1'b0;
  logic        dut_reset2, busy2, done2, pass2;
  logic [15:0] sig2;
  logic [1:0]  run2, fail2;
  int n_cmp = 0, n_err = 0;

  // Model signature equals GOLD (xor flip) only on the 100th cycle out of reset
  always @(posedge clk) mcnt <= dut_reset ? 16'h0 : mcnt + 16'h1;
  assign dut_signature = GOLD ^ mcnt ^ 16'd99 ^ {15'b0, flip};

  mult_bist_ctrl #(.GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop_en(loop_en),
    .dut_signature(dut_signature), .dut_reset(dut_reset), .busy(busy), .done(done),
    .pass(pass), .sig_captured(sig_captured), .run_count(run_count), .fail_count(fail_count)
  );
  mult_bist_ctrl #(.NUM_CYCLES(5), .RESET_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .abort(1'b0), .loop_en(loop2),
    .dut_signature(16'hFFFF), .dut_reset(dut_reset2), .busy(busy2), .done(done2),
    .pass(pass2), .sig_captured(sig2), .run_count(run2), .fail_count(fail2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    for (int i = 1; i <= 300 && c == 0; i++) begin
      tick();
      if (done) c = i;
    end
  endtask

  task automatic wait_done2(output int c);
    c = 0;
    for (int i = 1; i <= 50 && c == 0; i++) begin
      tick();
      if (done2) c = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if ({dut_reset, busy, done, pass} !== 4'b1000) begin n_err++; $display("FAIL reset_flags: got %b want 1000", {dut_reset, busy, done, pass}); end
    n_cmp++; if ({sig_captured, run_count, fail_count} !== 32'h0) begin n_err++; $display("FAIL reset_regs: got %h want 0", {sig_captured, run_count, fail_count}); end
  endtask

  task automatic test_pass();
    int hi, lo, dc;
    hi = 0; lo = 0; dc = 0;
    flip = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 300 && dc == 0; i++) begin
      if (done) dc = i;
      else begin
        if (!dut_reset) lo++;
        else if (lo == 0) hi++;
        tick();
      end
    end
    n_cmp++; if (hi !== 3) begin n_err++; $display("FAIL pass_hold_len: got %0d want 3", hi); end
    n_cmp++; if (lo !== 100) begin n_err++; $display("FAIL pass_run_len: got %0d want 100", lo); end
    n_cmp++; if (dc !== 105) begin n_err++; $display("FAIL pass_done_cycle: got %0d want 105", dc); end
    n_cmp++; if ({pass, run_count, fail_count} !== {1'b1, 8'd1, 8'd0}) begin n_err++; $display("FAIL pass_status: got %b/%0d/%0d want 1/1/0", pass, run_count, fail_count); end
    n_cmp++; if (sig_captured !== GOLD) begin n_err++; $display("FAIL pass_sig: got %h want %h", sig_captured, GOLD); end
    tick();
    n_cmp++; if ({done, busy, pass} !== 3'b001) begin n_err++; $display("FAIL pass_after: got %b want 001", {done, busy, pass}); end
  endtask

  task automatic test_fail();
    int c;
    flip = 1'b1;
    start = 1'b1;
    wait_done(c);
    start = 1'b0;
    n_cmp++; if (c !== 105) begin n_err++; $display("FAIL fail_done_cycle: got %0d want 105", c); end
    n_cmp++; if ({pass, run_count, fail_count} !== {1'b0, 8'd2, 8'd1}) begin n_err++; $display("FAIL fail_status: got %b/%0d/%0d want 0/2/1", pass, run_count, fail_count); end
    n_cmp++; if (sig_captured !== (GOLD ^ 16'h1)) begin n_err++; $display("FAIL fail_sig: got %h want %h", sig_captured, GOLD ^ 16'h1); end
    flip = 1'b0;
    tick();
  endtask

  task automatic test_loop();
    int c;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    loop_en = 1'b1;
    start = 1'b1;
    wait_done(c);
    start = 1'b0;
    n_cmp++; if (c !== 105) begin n_err++; $display("FAIL loop1_cycle: got %0d want 105", c); end
    n_cmp++; if ({pass, run_count, fail_count} !== {1'b1, 8'd1, 8'd0}) begin n_err++; $display("FAIL loop1_status: got %b/%0d/%0d want 1/1/0", pass, run_count, fail_count); end
    flip = 1'b1;
    wait_done(c);
    n_cmp++; if (c !== 105) begin n_err++; $display("FAIL loop2_gap: got %0d want 105", c); end
    n_cmp++; if ({pass, run_count, fail_count} !== {1'b0, 8'd2, 8'd1}) begin n_err++; $display("FAIL loop2_status: got %b/%0d/%0d want 0/2/1", pass, run_count, fail_count); end
    flip = 1'b0;
    wait_done(c);
    loop_en = 1'b0;
    n_cmp++; if (c !== 105) begin n_err++; $display("FAIL loop3_gap: got %0d want 105", c); end
    n_cmp++; if ({pass, run_count, fail_count} !== {1'b1, 8'd3, 8'd1}) begin n_err++; $display("FAIL loop3_status: got %b/%0d/%0d want 1/3/1", pass, run_count, fail_count); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL loop_stop: busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (52) tick();
    n_cmp++; if ({busy, dut_reset} !== 2'b10) begin n_err++; $display("FAIL abort_in_run: got %b want 10", {busy, dut_reset}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({busy, dut_reset, done, pass} !== 4'b0100) begin n_err++; $display("FAIL abort_flags: got %b want 0100", {busy, dut_reset, done, pass}); end
    n_cmp++; if ({sig_captured, run_count, fail_count} !== {GOLD, 8'd3, 8'd1}) begin n_err++; $display("FAIL abort_regs: got %h want %h", {sig_captured, run_count, fail_count}, {GOLD, 8'd3, 8'd1}); end
    wait_done(c);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL abort_no_done: done seen after %0d cycles, want none", c); end
  endtask

  task automatic test_ignore();
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    n_cmp++; if (c !== 93) begin n_err++; $display("FAIL ignore_start_run: done after %0d want 93", c); end
    n_cmp++; if (run_count !== 8'd4) begin n_err++; $display("FAIL ignore_runs: got %0d want 4", run_count); end
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++; if ({busy, dut_reset} !== 2'b01) begin n_err++; $display("FAIL start_abort_idle: got %b want 01", {busy, dut_reset}); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_abort_stay: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_hold();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if ({busy, dut_reset, pass} !== 3'b111) begin n_err++; $display("FAIL hold_before_reset: got %b want 111", {busy, dut_reset, pass}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({dut_reset, busy, done, pass} !== 4'b1000) begin n_err++; $display("FAIL midreset_flags: got %b want 1000", {dut_reset, busy, done, pass}); end
    n_cmp++; if ({sig_captured, run_count, fail_count} !== 32'h0) begin n_err++; $display("FAIL midreset_regs: got %h want 0", {sig_captured, run_count, fail_count}); end
    repeat (5) tick();
    n_cmp++; if ({busy, dut_reset} !== 2'b01) begin n_err++; $display("FAIL midreset_idle: got %b want 01", {busy, dut_reset}); end
  endtask

  task automatic test_saturate();
    int c, e;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    loop2 = 1'b1;
    start2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_done2(c);
      start2 = 1'b0;
      if (k == 5) loop2 = 1'b0;
      e = k < 3 ? k : 3;
      n_cmp++; if (c !== 9) begin n_err++; $display("FAIL sat_gap_%0d: got %0d want 9", k, c); end
      n_cmp++; if ({pass2, run2, fail2} !== {1'b0, 2'(e), 2'(e)}) begin n_err++; $display("FAIL sat_counts_%0d: got %b/%0d/%0d want 0/%0d/%0d", k, pass2, run2, fail2, e, e); end
    end
    n_cmp++; if (sig2 !== 16'hFFFF) begin n_err++; $display("FAIL sat_sig: got %h want ffff", sig2); end
    tick();
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL sat_stop: busy got %b want 0", busy2); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_loop();
    test_abort();
    test_ignore();
    test_reset_mid_hold();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
